suma_resta_serial: RTL and testbench
====================================

# suma_resta_serial

Digit-serial, registered add/subtract unit with status flags for the lab ALU datapath. It processes an M-bit operand pair D bits per clock and supports plain and carry-chained add/subtract for multi-precision arithmetic. It uses a start/done handshake and holds its result and flags stable between operations. It replaces the purely combinational ripple subtractor wherever a clocked, flag-correct unit is needed.

## Interface
- M, default 8: operand/result width; must be a multiple of D.
- D, default 2: bits processed per clock; 1 ≤ D ≤ M.

- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- op  input  2  00 ADD (A+B), 01 SUB (A−B), 10 ADC (A+B+Cst), 11 SBC (A+~B+Cst).
- A  input  M  operand A; latched on accepted start.
- B  input  M  operand B; latched on accepted start.
- ready  output  1  high when a start can be accepted (state ≠ RUN).
- done  output  1  one-cycle pulse when R/flags are updated.
- R  output  M  result.
- C  output  1  carry out of the MSB. For SUB/SBC, 1 means no borrow.
- N  output  1  R[M−1].
- V  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- Z  output  1  R == 0 for this operation only. Independent of C.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 → RUN.
  - RUN: digit counter 0..M/D−1; last digit → DONE.
  - DONE: start=1 → RUN; otherwise → IDLE.
- On accepted start:
  - Latch A, B and op.
  - Invert B for SUB/SBC.
  - Initial carry cin0: ADD=0, SUB=1, ADC/SBC=Cst.
- Each RUN cycle adds one D-bit digit, LSB first, through a D-bit ripple stage. The internal carry register carries between digits.
- Partial results go into an internal shift register. R changes only at completion, so R never shows partial values.
- Completion (final digit):
  - Write R and C, N, V, Z together.
  - Update Cst (the stored carry) to the new C.
- Cst persists across operations and is cleared only by reset. This allows chained ADC/SBC over multiple words.
- start while in RUN: ignored, with no effect on the operation in flight.
- Reset at any time:
  - State → IDLE; R=0, C=N=V=Z=0, done=0, Cst=0, ready=1.
  - Any operation in flight is aborted with no done pulse.
- Outputs after reset: R=0, C=0, N=0, V=0, Z=0, done=0, ready=1.

## Timing
- Start sampled at edge t0 (ready=1). The RUN digits are processed at edges t0+1 … t0+M/D.
- R, flags and done are registered at edge t0+M/D. done is high for exactly one cycle.
- Latency from start to done is M/D cycles. Default: 4 cycles.
- ready is low from edge t0 through edge t0+M/D−1, and high in the DONE cycle.
- Back-to-back: start=1 during the done cycle is accepted. The next operation's done arrives M/D cycles later, so throughput is one operation per M/D cycles.
- Between operations, R and flags hold their last values indefinitely.

## Configuration
- SUMRES_SAT_EN defined:
  - ADD and SUB with V=1 saturate R: 2^(M−1)−1 on positive overflow, −2^(M−1) on negative overflow.
  - V still reads 1. N and Z are computed from the saturated R.
  - C and Cst keep the raw carry.
  - ADC/SBC never saturate.
- SUMRES_SAT_EN undefined: R always wraps modulo 2^M.

## Test plan
- Reset with M=8, D=2, then ADD 0x7F+0x01 → done 4 cycles after the start edge. Without the macro: R=0x80, N=1, V=1, C=0, Z=0. With SUMRES_SAT_EN: R=0x7F, N=0, V=1.
- SUB 0x05−0x05 → R=0x00, Z=1, C=1, N=0, V=0. SUB 0x03−0x05 → R=0xFE, C=0, N=1, V=0, Z=0.
- Chain: ADD 0xFF+0x01 → R=0x00, C=1, Z=1. Then ADC 0x00+0x00 → R=0x01, C=0, Z=0. Then SBC 0x00−0x00 with Cst=0 → R=0xFF, C=0.
- Hold start high during RUN of ADD 0x10+0x20 → only one done, R=0x30, and ready stays low for 4 cycles. A start asserted in the done cycle (SUB 0x30−0x10) is accepted → R=0x20 four cycles later.
- Assert rst at the second RUN cycle of ADD 0x01+0x01 → outputs immediately 0 and ready=1. No done appears, and Cst=0 (verified by a following ADC 0x00+0x00 → R=0x00, Z=1).
- Parameter sweep with D=1, D=4 and D=M=8, random A/B/op → R and flags match the reference model, and done latency equals M/D.

Source files
------------

// File: rtl/suma_resta_serial.sv
// Digit-serial add/subtract (ADD/SUB/ADC/SBC) with C/N/V/Z flags and a stored carry for chaining.
// Optional saturation of ADD/SUB on signed overflow: define SUMRES_SAT_EN.
module suma_resta_serial #(
  parameter int M = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  output logic         ready,
  output logic         done,
  output logic [M-1:0] R,
  output logic         C,
  output logic         N,
  output logic         V,
  output logic         Z
);

  localparam int NDIG = M / D;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [M-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [1:0]    op_q, op_d;
  logic          carry_q, carry_d, cst_q, cst_d;
  logic [M-1:0]  r_q, r_d;
  logic          c_q, c_d, n_q, n_d, v_q, v_d, z_q, z_d;

  logic [D:0]    chain;
  logic [D-1:0]  sum_dig;
  logic [M-1:0]  sum_ext, res_raw, res_fin;
  logic          ovf;

  // One D-bit ripple stage; the digit result enters the shift register from the top.
  always_comb begin
    chain[0] = carry_q;
    sum_dig  = '0;
    for (int i = 0; i < D; i++) begin
      sum_dig[i]  = a_q[i] ^ b_q[i] ^ chain[i];
      chain[i+1]  = (a_q[i] & b_q[i]) | (chain[i] & (a_q[i] ^ b_q[i]));
    end
    sum_ext          = '0;
    sum_ext[D-1:0]   = sum_dig;
    res_raw          = (acc_q >> D) | (sum_ext << (M - D));
    ovf              = chain[D] ^ chain[D-1];
    res_fin          = res_raw;
`ifdef SUMRES_SAT_EN
    if (!op_q[1] && ovf)
      res_fin = res_raw[M-1] ? {1'b0, {(M-1){1'b1}}} : {1'b1, {(M-1){1'b0}}};
`endif
  end

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    op_d    = op_q;
    carry_d = carry_q;
    cst_d   = cst_q;
    r_d     = r_q;
    c_d     = c_q;
    n_d     = n_q;
    v_d     = v_q;
    z_d     = z_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = A;
          b_d     = op[0] ? ~B : B;
          op_d    = op;
          carry_d = op[1] ? cst_q : op[0];
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> D;
        b_d     = b_q >> D;
        acc_d   = res_raw;
        carry_d = chain[D];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NDIG - 1)) begin
          state_d = DONE;
          r_d     = res_fin;
          c_d     = chain[D];
          cst_d   = chain[D];
          v_d     = ovf;
          n_d     = res_fin[M-1];
          z_d     = (res_fin == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      cst_q   <= 1'b0;
      r_q     <= '0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      cst_q   <= cst_d;
      r_q     <= r_d;
      c_q     <= c_d;
      n_q     <= n_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  assign ready = (state_q != RUN);
  assign done  = (state_q == DONE);
  assign R     = r_q;
  assign C     = c_q;
  assign N     = n_q;
  assign V     = v_q;
  assign Z     = z_q;

endmodule

// File: tb/tb_suma_resta_serial.sv
// Scoreboard bench for suma_resta_serial: directed M=8/D=2 sequence plus a D=1/4/8 random sweep.
module tb_suma_resta_serial;

  localparam int M    = 8;
  localparam int NDIG = 4;

  logic clk, rst;
  logic start;
  logic [1:0] op;
  logic [M-1:0] a, b, r;
  logic ready, done, c, n, v, z;

  logic sw_start;
  logic [1:0] sw_op;
  logic [M-1:0] sw_a, sw_b;
  logic sw_ready [3];
  logic sw_done [3];
  logic [M-1:0] sw_r [3];
  logic sw_c [3], sw_n [3], sw_v [3], sw_z [3];

  typedef struct {
    logic [11:0] res;
    int          t;
  } sb_t;

  sb_t  exp_q[$];
  logic m_cst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  suma_resta_serial #(.M(M), .D(2)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(a), .B(b),
    .ready(ready), .done(done), .R(r), .C(c), .N(n), .V(v), .Z(z)
  );

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int DG = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
    suma_resta_serial #(.M(M), .D(DG)) u_sw (
      .clk(clk), .rst(rst), .start(sw_start), .op(sw_op), .A(sw_a), .B(sw_b),
      .ready(sw_ready[g]), .done(sw_done[g]), .R(sw_r[g]),
      .C(sw_c[g]), .N(sw_n[g]), .V(sw_v[g]), .Z(sw_z[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference: 9-bit sum, overflow from operand/result signs.
  function automatic logic [11:0] model(input logic [1:0] o, input logic [7:0] aa,
                                        input logic [7:0] bb, input logic cs);
    logic [7:0] bx, rr;
    logic [8:0] s;
    logic ci, vv;
    bx = o[0] ? ~bb : bb;
    ci = o[1] ? cs : o[0];
    s  = {1'b0, aa} + {1'b0, bx} + {8'd0, ci};
    rr = s[7:0];
    vv = (aa[7] == bx[7]) && (rr[7] != aa[7]);
`ifdef SUMRES_SAT_EN
    if (!o[1] && vv) rr = rr[7] ? 8'h7F : 8'h80;
`endif
    return {rr, s[8], rr[7], vv, (rr == 8'h00)};
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      sb_t e;
      done_cnt++;
      check("ready_in_done", {31'd0, ready}, 32'd1);
      if (exp_q.size() == 0) begin
        check("spurious_done", exp_q.size(), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("result", {20'd0, r, c, n, v, z}, {20'd0, e.res});
        check("latency", cyc - e.t, NDIG);
      end
    end
  end

  task automatic step(input logic s, input logic [1:0] o, input logic [7:0] aa,
                      input logic [7:0] bb, output logic rdy);
    sb_t e;
    @(negedge clk);
    start = s;
    op    = o;
    a     = aa;
    b     = bb;
    rdy   = ready;
    if (s && ready && !rst) begin
      e.res = model(o, aa, bb, m_cst);
      e.t   = cyc + 1;
      m_cst = e.res[3];
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    logic rd;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, 2'b00, 8'h00, 8'h00, rd);
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [7:0] aa, input logic [7:0] bb);
    logic rd;
    step(1'b1, o, aa, bb, rd);
    drain();
  endtask

  task automatic chk_out(input string tag, input logic [11:0] want);
    check(tag, {20'd0, r, c, n, v, z}, {20'd0, want});
  endtask

  initial begin
    logic rd;
    int   dc;
    int   lat [3];
    int   lat_exp [3];
    logic sw_cst;
    logic [11:0] e_sw;
    logic [1:0]  o;
    logic [7:0]  aa, bb;

    lat_exp = '{8, 2, 1};
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; m_cst = 1'b0;
    sw_start = 1'b0; sw_op = 2'b00; sw_a = '0; sw_b = '0;
    repeat (2) @(negedge clk);
    check("rst_out", {18'd0, r, c, n, v, z, done, ready}, 32'h1);
    rst = 1'b0;

    run_op(2'b00, 8'h7F, 8'h01);
`ifdef SUMRES_SAT_EN
    chk_out("add_7f_01", {8'h7F, 1'b0, 1'b0, 1'b1, 1'b0});
`else
    chk_out("add_7f_01", {8'h80, 1'b0, 1'b1, 1'b1, 1'b0});
`endif
    run_op(2'b01, 8'h05, 8'h05);
    chk_out("sub_05_05", {8'h00, 1'b1, 1'b0, 1'b0, 1'b1});
    run_op(2'b01, 8'h03, 8'h05);
    chk_out("sub_03_05", {8'hFE, 1'b0, 1'b1, 1'b0, 1'b0});
    run_op(2'b00, 8'hFF, 8'h01);
    chk_out("add_ff_01", {8'h00, 1'b1, 1'b0, 1'b0, 1'b1});
    run_op(2'b10, 8'h00, 8'h00);
    chk_out("adc_chain", {8'h01, 1'b0, 1'b0, 1'b0, 1'b0});
    run_op(2'b11, 8'h00, 8'h00);
    chk_out("sbc_chain", {8'hFF, 1'b0, 1'b1, 1'b0, 1'b0});

    // start held high through RUN, then a back-to-back SUB in the done cycle
    dc = done_cnt;
    step(1'b1, 2'b00, 8'h10, 8'h20, rd);
    for (int i = 0; i < NDIG; i++) begin
      step(1'b1, 2'b00, 8'h10, 8'h20, rd);
      check("ready_low_run", {31'd0, rd}, 32'd0);
    end
    step(1'b1, 2'b01, 8'h30, 8'h10, rd);
    check("ready_done_cycle", {31'd0, rd}, 32'd1);
    step(1'b0, 2'b00, 8'h00, 8'h00, rd);
    drain();
    repeat (2) step(1'b0, 2'b00, 8'h00, 8'h00, rd);
    check("hold_done_count", done_cnt - dc, 32'd2);
    chk_out("b2b_sub", {8'h20, 1'b1, 1'b0, 1'b0, 1'b0});

    // reset in the middle of RUN aborts the op and clears the stored carry
    step(1'b1, 2'b00, 8'h01, 8'h01, rd);
    step(1'b0, 2'b00, 8'h00, 8'h00, rd);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_out", {18'd0, r, c, n, v, z, done, ready}, 32'h1);
    exp_q.delete();
    m_cst = 1'b0;
    dc = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) step(1'b0, 2'b00, 8'h00, 8'h00, rd);
    check("abort_no_done", done_cnt - dc, 32'd0);
    run_op(2'b10, 8'h00, 8'h00);
    chk_out("adc_after_rst", {8'h00, 1'b0, 1'b0, 1'b0, 1'b1});

    // D sweep: all three instances share stimulus, so they share the stored carry
    sw_cst = 1'b0;
    for (int t = 0; t < 24; t++) begin
      o    = 2'($urandom_range(0, 3));
      aa   = 8'($urandom);
      bb   = 8'($urandom);
      if (t == 0) begin o = 2'b00; aa = 8'h7F; bb = 8'h01; end
      if (t == 1) begin o = 2'b01; aa = 8'h80; bb = 8'h01; end
      e_sw   = model(o, aa, bb, sw_cst);
      sw_cst = e_sw[3];
      @(negedge clk);
      sw_start = 1'b1; sw_op = o; sw_a = aa; sw_b = bb;
      lat = '{-1, -1, -1};
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        if (k == 1) sw_start = 1'b0;
        for (int g = 0; g < 3; g++) begin
          if (lat[g] < 0 && sw_done[g]) begin
            lat[g] = k - 1;
            check("sw_result", {20'd0, sw_r[g], sw_c[g], sw_n[g], sw_v[g], sw_z[g]},
                  {20'd0, e_sw});
            check("sw_latency", lat[g], lat_exp[g]);
          end
        end
        if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
      end
      for (int g = 0; g < 3; g++)
        if (lat[g] < 0) check("sw_timeout", g, 32'hFFFF_FFFF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
